// File: rtl/sram_pdp_be.sv
// Pseudo dual port SRAM: write-only port A with byte enables, read-only port B
// with 1- or 2-cycle registered latency, read-valid strobe and collision flag.
module sram_pdp_be #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 32,
  parameter  int BYTE   = 8,
  parameter  int RD_LAT = 1,
  parameter  int BYPASS = 1,
  localparam int NLANE  = WIDTH / BYTE,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             we_A,
  input  logic [AW-1:0]    add_A,
  input  logic [NLANE-1:0] be_A,
  input  logic [WIDTH-1:0] data_inA,
  input  logic             re_B,
  input  logic [AW-1:0]    add_B,
  output logic [WIDTH-1:0] data_outB,
  output logic             valid_B,
  output logic             coll_B
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  if ((WIDTH % BYTE != 32'sd0) || (RD_LAT < 32'sd1) || (RD_LAT > 32'sd2) ||
      (DEPTH < 32'sd2)) begin : g_param_err
    $error("sram_pdp_be: illegal parameters (WIDTH%%BYTE, RD_LAT or DEPTH)");
  end

  logic             w_a_ok;
  logic             w_b_ok;
  logic             w_wr;
  logic             w_rd;
  logic             w_coll;
  logic [WIDTH-1:0] w_rdata;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_v1;
  logic             r_c1;
  logic [WIDTH-1:0] r_d1;

  assign w_a_ok = ({1'b0, add_A} < DEPTH_L);
  assign w_b_ok = ({1'b0, add_B} < DEPTH_L);
  assign w_wr   = rst_n & cs & we_A & w_a_ok;
  assign w_rd   = cs & re_B;
  assign w_coll = w_wr & re_B & (add_A == add_B);

  // Lane-masked write; the array itself is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int i = 32'sd0; i < NLANE; i++) begin
      if (w_wr && be_A[i]) begin
        r_mem[add_A][i*BYTE +: BYTE] <= data_inA[i*BYTE +: BYTE];
      end
    end
  end

  // Read word as seen at this edge: out-of-range reads yield zero, and on a
  // collision the write-first policy forwards the enabled lanes of data_inA.
  always_comb begin
    w_rdata = '0;
    if (w_b_ok) begin
      for (int i = 32'sd0; i < NLANE; i++) begin
        if ((BYPASS == 32'sd1) && w_coll && be_A[i]) begin
          w_rdata[i*BYTE +: BYTE] = data_inA[i*BYTE +: BYTE];
        end else begin
          w_rdata[i*BYTE +: BYTE] = r_mem[add_B][i*BYTE +: BYTE];
        end
      end
    end else begin
      w_rdata = '0;
    end
  end

  // First read stage; data holds its last value across idle slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_c1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd;
      r_c1 <= w_coll;
      if (w_rd) begin
        r_d1 <= w_rdata;
      end
    end
  end

  if (RD_LAT == 32'sd2) begin : g_lat2
    logic             r_v2;
    logic             r_c2;
    logic [WIDTH-1:0] r_d2;

    // Second stage delays the strobe, flag and data by one more edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v2 <= 1'b0;
        r_c2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        r_c2 <= r_c1;
        if (r_v1) begin
          r_d2 <= r_d1;
        end
      end
    end

    assign data_outB = r_d2;
    assign valid_B   = r_v2;
    assign coll_B    = r_c2;
  end else begin : g_lat1
    assign data_outB = r_d1;
    assign valid_B   = r_v1;
    assign coll_B    = r_c1;
  end

endmodule

// File: tb/tb_sram_pdp_be.sv
// Bench for sram_pdp_be: four instances covering latency, collision policy and
// non-power-of-two depth, checked by directed tables and a reference model.
module tb_sram_pdp_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cs, we_A, re_B;
  logic [3:0]  add_A, add_B, be_A;
  logic [31:0] data_inA;
  logic [31:0] o_d [4];
  logic        o_v [4];
  logic        o_c [4];

  sram_pdp_be #(.DEPTH(16), .WIDTH(32), .BYTE(8), .RD_LAT(1), .BYPASS(1)) u_i0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .add_A(add_A), .be_A(be_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B),
    .data_outB(o_d[0]), .valid_B(o_v[0]), .coll_B(o_c[0]));
  sram_pdp_be #(.DEPTH(16), .WIDTH(32), .BYTE(8), .RD_LAT(2), .BYPASS(0)) u_i1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .add_A(add_A), .be_A(be_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B),
    .data_outB(o_d[1]), .valid_B(o_v[1]), .coll_B(o_c[1]));
  sram_pdp_be #(.DEPTH(12), .WIDTH(32), .BYTE(8), .RD_LAT(2), .BYPASS(1)) u_i2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .add_A(add_A), .be_A(be_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B),
    .data_outB(o_d[2]), .valid_B(o_v[2]), .coll_B(o_c[2]));
  sram_pdp_be #(.DEPTH(12), .WIDTH(32), .BYTE(8), .RD_LAT(1), .BYPASS(0)) u_i3 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_A(we_A), .add_A(add_A), .be_A(be_A),
    .data_inA(data_inA), .re_B(re_B), .add_B(add_B),
    .data_outB(o_d[3]), .valid_B(o_v[3]), .coll_B(o_c[3]));

  int dep [4] = '{16, 16, 12, 12};
  int lat [4] = '{1, 2, 2, 1};
  int byp [4] = '{1, 0, 1, 0};

  typedef struct {
    logic        v;
    logic        c;
    logic [31:0] d;
  } res_t;

  typedef struct {
    logic        cs;
    logic        we;
    logic [3:0]  aa;
    logic [3:0]  be;
    logic [31:0] din;
    logic        re;
    logic [3:0]  ab;
    logic [33:0] a_exp;
    logic [33:0] b_exp;
  } vec_t;

  localparam int HMAX = 2048;
  res_t        hist [4][HMAX];
  logic [31:0] mm [4][16];
  logic [31:0] exp_d [4];
  int          t, base_t, n_tests, n_fail;
  vec_t        vt [9];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got v/c/d=%b/%b/%08h required %b/%b/%08h",
               name, act[33], act[32], act[31:0], req[33], req[32], req[31:0]);
    end
  endtask

  function automatic logic [33:0] outs(input int i);
    return {o_v[i], o_c[i], o_d[i]};
  endfunction

  task automatic drive(input logic c, input logic w, input logic [3:0] aa,
                       input logic [3:0] be, input logic [31:0] din,
                       input logic r, input logic [3:0] ab);
    cs = c; we_A = w; add_A = aa; be_A = be; data_inA = din; re_B = r; add_B = ab;
  endtask

  // One clock slot: the model predicts the slot, the edge happens, all four
  // instances are compared against the prediction that is due at this edge.
  task automatic step();
    int   s;
    int   j;
    logic ev, ec;
    res_t r;
    s = t;
    if (s >= HMAX) begin
      $display("FAIL hist_overflow: got slot %0d required < %0d", s, HMAX);
      $fatal(1, "history overflow");
    end
    for (int i = 0; i < 4; i++) begin
      r = '{1'b0, 1'b0, 32'h0};
      if (rst_n && cs && re_B) begin
        r.v = 1'b1;
        if (int'(add_B) < dep[i]) begin
          r.d = mm[i][add_B];
          if (we_A && add_A == add_B) begin
            r.c = 1'b1;
            if (byp[i] == 1)
              for (int l = 0; l < 4; l++)
                if (be_A[l]) r.d[8*l +: 8] = data_inA[8*l +: 8];
          end
        end
      end
      hist[i][s] = r;
      if (rst_n && cs && we_A && int'(add_A) < dep[i])
        for (int l = 0; l < 4; l++)
          if (be_A[l]) mm[i][add_A][8*l +: 8] = data_inA[8*l +: 8];
    end
    t++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ev = 1'b0;
      ec = 1'b0;
      if (!rst_n) begin
        exp_d[i] = 32'h0;
      end else begin
        j = s - (lat[i] - 1);
        if (j >= base_t) begin
          ev = hist[i][j].v;
          ec = hist[i][j].c;
          if (ev) exp_d[i] = hist[i][j].d;
        end
      end
      chk($sformatf("model_i%0d_slot%0d", i, s), outs(i), {ev, ec, exp_d[i]});
    end
    if (!rst_n) base_t = t;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; t = 0; base_t = 0;
    for (int i = 0; i < 4; i++) exp_d[i] = 32'h0;

    vt[0] = '{1'b1, 1'b1, 4'd3, 4'hF, 32'hAABBCCDD, 1'b0, 4'd0, {2'b00, 32'h0000010F}, {2'b00, 32'h0000010F}};
    vt[1] = '{1'b1, 1'b1, 4'd3, 4'h5, 32'h11223344, 1'b0, 4'd0, {2'b00, 32'h0000010F}, {2'b00, 32'h0000010F}};
    vt[2] = '{1'b1, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 4'd3, {2'b10, 32'hAA22CC44}, {2'b00, 32'h0000010F}};
    vt[3] = '{1'b1, 1'b1, 4'd5, 4'hF, 32'h00000000, 1'b0, 4'd0, {2'b00, 32'hAA22CC44}, {2'b10, 32'hAA22CC44}};
    vt[4] = '{1'b1, 1'b1, 4'd5, 4'h3, 32'hFFFFFFFF, 1'b1, 4'd5, {2'b11, 32'h0000FFFF}, {2'b00, 32'hAA22CC44}};
    vt[5] = '{1'b1, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 4'd5, {2'b10, 32'h0000FFFF}, {2'b11, 32'h00000000}};
    vt[6] = '{1'b0, 1'b1, 4'd2, 4'hF, 32'hDEADBEEF, 1'b1, 4'd2, {2'b00, 32'h0000FFFF}, {2'b10, 32'h0000FFFF}};
    vt[7] = '{1'b1, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b1, 4'd2, {2'b10, 32'h00000102}, {2'b00, 32'h0000FFFF}};
    vt[8] = '{1'b0, 1'b0, 4'd0, 4'h0, 32'h00000000, 1'b0, 4'd0, {2'b00, 32'h00000102}, {2'b10, 32'h00000102}};

    // Power-up reset, then a read in flight is killed by an async reset.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("reset_i%0d", i), outs(i), 34'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b1, 4'd0, 4'hF, 32'h0BADF00D, 1'b0, 4'd0);
    step();
    drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0);
    step();
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("async_rst_i%0d", i), outs(i), 34'h0);
      exp_d[i] = 32'h0;
    end
    base_t = t;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("no_pulse_after_release", outs(1), 34'h0);
    drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0);
    step();
    chk("first_read_lat1", outs(0), {2'b10, 32'h0BADF00D});
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    step();
    chk("first_read_lat2", outs(1), {2'b10, 32'h0BADF00D});

    // Fill every address, then stream reads back-to-back.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 4'(k), 4'hF, 32'h100 + 32'(k), 1'b0, 4'd0);
      step();
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(k));
      step();
      chk($sformatf("stream_lat1_k%0d", k), outs(0), {2'b10, 32'h100 + 32'(k)});
      if (k > 0) chk($sformatf("stream_lat2_k%0d", k), outs(1), {2'b10, 32'h100 + 32'(k - 1)});
    end
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    step();
    chk("stream_lat2_last", outs(1), {2'b10, 32'h0000010F});
    chk("stream_lat1_idle", outs(0), {2'b00, 32'h0000010F});

    // Byte-enable merge, collision policies and chip-select gating.
    for (int v = 0; v < 9; v++) begin
      drive(vt[v].cs, vt[v].we, vt[v].aa, vt[v].be, vt[v].din, vt[v].re, vt[v].ab);
      step();
      chk($sformatf("vec%0d_wf_lat1", v), outs(0), vt[v].a_exp);
      chk($sformatf("vec%0d_ro_lat2", v), outs(1), vt[v].b_exp);
    end

    // Out-of-range address on the 12-deep instances.
    drive(1'b1, 1'b1, 4'd13, 4'hF, 32'h12345678, 1'b0, 4'd0);
    step();
    drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd13);
    step();
    chk("oob_d12_lat1", outs(3), {2'b10, 32'h0});
    chk("inrange_d16_lat1", outs(0), {2'b10, 32'h12345678});
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0);
    step();
    chk("oob_d12_lat2", outs(2), {2'b10, 32'h0});

    // Random traffic with biased collisions and one mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      cs       = ($urandom_range(9) != 0);
      we_A     = $urandom_range(1);
      re_B     = ($urandom_range(4) < 3);
      add_A    = 4'($urandom_range(15));
      add_B    = ($urandom_range(2) == 0) ? add_A : 4'($urandom_range(15));
      be_A     = 4'($urandom_range(15));
      data_inA = $urandom;
      if (n == 200) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
